// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment decode/capture blocks.
// Contents: segment pattern constants SEG_0..SEG_F (gate segments g..a, dp excluded),
// digit count NUM_DIGITS and the capture FSM state type ss_cap_state_t.
package ss_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StCommit
  } ss_cap_state_t;

endpackage

// File: rtl/ss_decode_capture_if.sv
// Segment-byte transfer interface.
// Signals: seg_in (byte {dp,g..a}), seg_valid, seg_ready (valid/ready handshake),
// frame_start (restart the current frame).
// Modports: master drives bytes, slave (the capture block) returns seg_ready.
interface ss_decode_capture_if;
  logic [7:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic       frame_start;

  modport master (
    output seg_in,
    output seg_valid,
    output frame_start,
    input  seg_ready
  );

  modport slave (
    input  seg_in,
    input  seg_valid,
    input  frame_start,
    output seg_ready
  );
endinterface

// File: rtl/seg_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Ports: pattern (gate segments g..a), known (pattern is in the display table),
// nibble (decoded value, 0 when unknown).
module seg_to_hex
  import ss_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       known,
  output logic [3:0] nibble
);

  always_comb begin
    known  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ss_decode_capture.sv
// Captures an 8-byte frame of seven-segment patterns (first byte = digit 7) into a shadow
// buffer and publishes decoded digits in one commit cycle.
// Ports: hz100 (clock), reset (sync, active high), seg (slave handshake: seg_in, seg_valid,
// seg_ready, frame_start), digits/flt_pt/bad_digit (last complete frame), frame_valid and
// timeout (one-cycle pulses), busy (frame partially received).
// Build option: define SS_DECODE_DP_EN to capture seg_in[7] into flt_pt; otherwise flt_pt = 0.
module ss_decode_capture
  import ss_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                        hz100,
  input  logic                        reset,
  ss_decode_capture_if.slave          seg,
  output logic [NUM_DIGITS-1:0][3:0]  digits,
  output logic [NUM_DIGITS-1:0]       flt_pt,
  output logic [NUM_DIGITS-1:0]       bad_digit,
  output logic                        frame_valid,
  output logic                        timeout,
  output logic                        busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  ss_cap_state_t               state_q;
  logic [2:0]                  idx_q;
  logic [CntW-1:0]             idle_q;
  logic [CntW-1:0]             idle_inc;
  logic [NUM_DIGITS-1:0][3:0]  sh_dig_q, dig_nx;
  logic [NUM_DIGITS-1:0]       sh_bad_q, bad_nx;
  logic                        known;
  logic [3:0]                  nibble;
  logic                        xfer, restart, commit_now, time_out;
  logic [2:0]                  wr_idx;

  seg_to_hex u_seg_to_hex (
    .pattern (seg.seg_in[6:0]),
    .known   (known),
    .nibble  (nibble)
  );

  assign seg.seg_ready = ~reset & (state_q != StCommit);
  assign busy          = (state_q == StCapture);
  assign xfer          = seg.seg_valid & seg.seg_ready;
  assign restart       = seg.frame_start & (state_q == StCapture);
  // A byte arriving with frame_start lands in digit 7 of the new frame.
  assign wr_idx        = restart ? 3'd7 : idx_q;
  assign idle_inc      = (idle_q == {CntW{1'b1}}) ? idle_q : idle_q + CntW'(1);
  assign commit_now    = (state_q == StCapture) & xfer & (wr_idx == 3'd0);
  // A transfer in the same cycle wins over the timeout.
  assign time_out      = (state_q == StCapture) & ~xfer & (idle_inc == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    dig_nx = restart ? '0 : sh_dig_q;
    bad_nx = restart ? '0 : sh_bad_q;
    if (xfer) begin
      dig_nx[wr_idx] = known ? nibble : 4'h0;
      bad_nx[wr_idx] = ~known;
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 3'd7;
      idle_q      <= '0;
      sh_dig_q    <= '0;
      sh_bad_q    <= '0;
      digits      <= '0;
      bad_digit   <= '0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
      if (commit_now) begin
        // Outputs load here so they are visible throughout the COMMIT cycle.
        digits      <= dig_nx;
        bad_digit   <= bad_nx;
        frame_valid <= 1'b1;
        state_q     <= StCommit;
        idx_q       <= 3'd7;
        idle_q      <= '0;
        sh_dig_q    <= '0;
        sh_bad_q    <= '0;
      end else if (time_out) begin
        timeout  <= 1'b1;
        state_q  <= StIdle;
        idx_q    <= 3'd7;
        idle_q   <= '0;
        sh_dig_q <= '0;
        sh_bad_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (xfer) begin
              state_q  <= StCapture;
              idx_q    <= wr_idx - 3'd1;
              idle_q   <= '0;
              sh_dig_q <= dig_nx;
              sh_bad_q <= bad_nx;
            end
          end
          StCapture: begin
            sh_dig_q <= dig_nx;
            sh_bad_q <= bad_nx;
            if (xfer) begin
              idx_q  <= wr_idx - 3'd1;
              idle_q <= '0;
            end else begin
              idx_q  <= wr_idx;
              idle_q <= idle_inc;
            end
          end
          StCommit: state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef SS_DECODE_DP_EN
  logic [NUM_DIGITS-1:0] sh_dp_q, dp_nx;

  always_comb begin
    dp_nx = restart ? '0 : sh_dp_q;
    if (xfer) begin
      dp_nx[wr_idx] = seg.seg_in[7];
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      sh_dp_q <= '0;
      flt_pt  <= '0;
    end else if (commit_now) begin
      flt_pt  <= dp_nx;
      sh_dp_q <= '0;
    end else if (time_out) begin
      sh_dp_q <= '0;
    end else if (state_q != StCommit) begin
      sh_dp_q <= dp_nx;
    end
  end
`else
  assign flt_pt = '0;
`endif

endmodule

// File: tb/tb_ss_decode_capture.sv
module tb_ss_decode_capture;
  localparam int TIMEOUT = 100;

  logic        hz100 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] digits;
  logic [7:0]  flt_pt, bad_digit;
  logic        frame_valid, timeout, busy;

  int checks = 0;
  int errors = 0;

  ss_decode_capture_if sif ();

  ss_decode_capture #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .seg         (sif.slave),
    .digits      (digits),
    .flt_pt      (flt_pt),
    .bad_digit   (bad_digit),
    .frame_valid (frame_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 hz100 = ~hz100;

  // Reference model: frame as a queue of received bytes, decoded only at commit.
  localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]  mq[$];
  bit          m_in_frame, m_commit, m_fv, m_to;
  int          m_idle;
  logic [31:0] m_dig;
  logic [7:0]  m_bad, m_dp;

  task automatic model_reset();
    mq.delete();
    m_in_frame = 0; m_commit = 0; m_fv = 0; m_to = 0; m_idle = 0;
    m_dig = '0; m_bad = '0; m_dp = '0;
  endtask

  task automatic model_publish();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      bit         kn;
      logic [3:0] nib;
      b = mq[k]; kn = 0; nib = 4'h0;
      for (int h = 0; h < 16; h++) begin
        if (b[6:0] == TBL[h]) begin kn = 1; nib = 4'(h); end
      end
      m_dig[(7-k)*4 +: 4] = nib;
      m_bad[7-k] = !kn;
`ifdef SS_DECODE_DP_EN
      m_dp[7-k] = b[7];
`else
      m_dp[7-k] = 1'b0;
`endif
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit fs);
    m_fv = 0; m_to = 0;
    if (m_commit) begin
      m_commit = 0;
    end else begin
      if (fs && m_in_frame) mq.delete();
      if (v) begin
        mq.push_back(b); m_idle = 0; m_in_frame = 1;
        if (mq.size() == 8) begin
          model_publish();
          mq.delete(); m_in_frame = 0; m_commit = 1; m_fv = 1;
        end
      end else if (m_in_frame) begin
        m_idle++;
        if (m_idle >= TIMEOUT) begin
          m_to = 1; mq.delete(); m_in_frame = 0; m_idle = 0;
        end
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model, and returns 1 ns after the edge.
  task automatic cycle(input bit v, input logic [7:0] b, input bit fs);
    sif.seg_valid = v; sif.seg_in = b; sif.frame_start = fs;
    model_step(v, b, fs);
    @(posedge hz100); #1;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1; sif.seg_valid = 1'b0; sif.frame_start = 1'b0; sif.seg_in = 8'h00;
    model_reset();
    repeat (n) begin @(posedge hz100); #1; end
  endtask

  task automatic test_reset();
    reset_cycles(2);
    checks++; if (sif.seg_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %b want 0", sif.seg_ready); end
    checks++; if ({digits, flt_pt, bad_digit, frame_valid, timeout, busy} !== '0) begin errors++;
      $display("FAIL reset_outputs got %h/%h/%h/%b%b%b want all 0",
               digits, flt_pt, bad_digit, frame_valid, timeout, busy); end
    reset = 1'b0;
    cycle(0, 8'h00, 0);
    checks++; if (sif.seg_ready !== 1'b1) begin errors++;
      $display("FAIL ready_after_reset got %b want 1", sif.seg_ready); end
  endtask

  task automatic test_badbad();
    logic [7:0] f [8] = '{8'h7C, 8'h77, 8'h5E, 8'h7C, 8'h77, 8'h5E, 8'h3F, 8'h3F};
    for (int i = 0; i < 8; i++) begin
      checks++; if (frame_valid !== 1'b0) begin errors++;
        $display("FAIL badbad_early_fv byte %0d got %b want 0", i, frame_valid); end
      cycle(1, f[i], 0);
    end
    checks++; if (frame_valid !== 1'b1 || sif.seg_ready !== 1'b0) begin errors++;
      $display("FAIL badbad_commit fv=%b ready=%b want 1/0", frame_valid, sif.seg_ready); end
    checks++; if (digits !== 32'hBADBAD00 || bad_digit !== 8'h00) begin errors++;
      $display("FAIL badbad_digits got %h/%h want BADBAD00/00", digits, bad_digit); end
    cycle(0, 8'h00, 0);
    checks++; if (frame_valid !== 1'b0 || digits !== 32'hBADBAD00) begin errors++;
      $display("FAIL badbad_after fv=%b digits=%h want 0/BADBAD00", frame_valid, digits); end
  endtask

  task automatic test_bad_pattern();
    logic [7:0] f [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h00, 8'h6D, 8'h7D, 8'h07};
    for (int i = 0; i < 8; i++) cycle(1, f[i], 0);
    checks++; if (digits !== 32'h01230567 || bad_digit !== 8'h08 || frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL bad_pattern got %h/%h fv=%b want 01230567/08/1", digits, bad_digit, frame_valid);
    end
    cycle(0, 8'h00, 0);
  endtask

  task automatic test_dp();
    logic [7:0] f [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'hBF};
    logic [7:0] want_dp;
`ifdef SS_DECODE_DP_EN
    want_dp = 8'h01;
`else
    want_dp = 8'h00;
`endif
    for (int i = 0; i < 8; i++) cycle(1, f[i], 0);
    checks++; if (digits !== 32'h01234560 || flt_pt !== want_dp || bad_digit !== 8'h00) begin
      errors++;
      $display("FAIL dp got %h/%h/%h want 01234560/%h/00", digits, flt_pt, bad_digit, want_dp);
    end
    cycle(0, 8'h00, 0);
  endtask

  task automatic test_timeout();
    logic [31:0] prior;
    prior = digits;
    for (int i = 0; i < 3; i++) cycle(1, TBL[i+8], 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle(0, 8'h00, 0);
      if (i == TIMEOUT - 1) begin
        checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++;
          $display("FAIL timeout_early to=%b busy=%b want 0/1", timeout, busy); end
      end
    end
    checks++; if (timeout !== 1'b1 || busy !== 1'b0 || digits !== prior) begin errors++;
      $display("FAIL timeout_fire to=%b busy=%b digits=%h want 1/0/%h", timeout, busy, digits, prior);
    end
    cycle(0, 8'h00, 0);
    checks++; if (timeout !== 1'b0) begin errors++;
      $display("FAIL timeout_pulse_width got %b want 0", timeout); end
    // Next frame starts fresh at digit 7.
    for (int i = 0; i < 8; i++) cycle(1, TBL[15-i], 0);
    checks++; if (digits !== 32'hFEDCBA98 || frame_valid !== 1'b1) begin errors++;
      $display("FAIL timeout_next_frame got %h fv=%b want FEDCBA98/1", digits, frame_valid); end
    cycle(0, 8'h00, 0);
  endtask

  task automatic test_restart();
    int fv_count = 0;
    for (int i = 0; i < 5; i++) begin cycle(1, TBL[i], 0); fv_count += int'(frame_valid); end
    cycle(1, 8'h71, 1); fv_count += int'(frame_valid);
    for (int i = 0; i < 7; i++) begin cycle(1, TBL[i+1], 0); fv_count += int'(frame_valid); end
    checks++; if (digits[31:28] !== 4'hF || digits !== 32'hF1234567) begin errors++;
      $display("FAIL restart_digits got %h want F1234567", digits); end
    cycle(0, 8'h00, 0); fv_count += int'(frame_valid);
    checks++; if (fv_count != 1) begin errors++;
      $display("FAIL restart_fv_count got %0d want 1", fv_count); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 4; i++) cycle(1, TBL[i+4], 0);
    sif.seg_valid = 1'b1;
    reset_cycles(1);
    checks++; if ({digits, flt_pt, bad_digit, frame_valid, timeout, busy} !== '0) begin errors++;
      $display("FAIL midframe_reset got %h/%h/%h/%b%b%b want all 0",
               digits, flt_pt, bad_digit, frame_valid, timeout, busy); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1, TBL[7-i], 0);
    checks++; if (digits !== 32'h76543210 || frame_valid !== 1'b1 || bad_digit !== 8'h00) begin
      errors++;
      $display("FAIL midframe_clean got %h fv=%b bad=%h want 76543210/1/00",
               digits, frame_valid, bad_digit);
    end
    cycle(0, 8'h00, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      bit         v, fs;
      logic [7:0] b;
      if ($urandom_range(0, 400) == 0) begin
        repeat ($urandom_range(TIMEOUT - 2, TIMEOUT + 3)) cycle(0, 8'h00, 0);
      end
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 30) == 0);
      b  = ($urandom_range(0, 9) == 0) ? 8'($urandom) :
           {1'($urandom), TBL[$urandom_range(0, 15)]};
      cycle(v, b, fs);
      checks++; if ({frame_valid, timeout, busy, sif.seg_ready} !== {m_fv, m_to, m_in_frame, !m_commit})
      begin errors++;
        $display("FAIL rand_ctrl cyc %0d fv/to/busy/rdy got %b%b%b%b want %b%b%b%b", n,
                 frame_valid, timeout, busy, sif.seg_ready, m_fv, m_to, m_in_frame, !m_commit);
      end
      checks++; if (digits !== m_dig || bad_digit !== m_bad || flt_pt !== m_dp) begin errors++;
        $display("FAIL rand_data cyc %0d got %h/%h/%h want %h/%h/%h", n,
                 digits, bad_digit, flt_pt, m_dig, m_bad, m_dp);
      end
    end
  endtask

  initial begin
    sif.seg_valid = 1'b0; sif.seg_in = 8'h00; sif.frame_start = 1'b0;
    test_reset();
    test_badbad();
    test_bad_pattern();
    test_dp();
    test_timeout();
    test_restart();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss_decode_capture.md
SS_DECODE_CAPTURE -- requirements
Module: ss_decode_capture

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100, meaning the idle cycles allowed between accepted bytes inside a frame (1 s at hz100).
REQ-002 SHALL have port hz100  in  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port seg_in  in  8  segment byte {dp, g, f, e, d, c, b, a}; bit0 = a.
REQ-005 SHALL have port seg_valid  in  1  seg_in holds a byte to transfer.
REQ-006 SHALL have port seg_ready  out  1  block can accept a byte this cycle.
REQ-007 SHALL have port frame_start  in  1  abandon any partial frame; next byte is digit 7.
REQ-008 SHALL have port digits  out  [7:0][3:0]  decoded hex digits of the last complete frame.
REQ-009 SHALL have port flt_pt  out  8  decimal-point bits of the last complete frame.
REQ-010 SHALL have port bad_digit  out  8  bit i set when digit i's pattern was unrecognised.
REQ-011 SHALL have port frame_valid  out  1  one-cycle pulse when the outputs update.
REQ-012 SHALL have port timeout  out  1  one-cycle pulse when a partial frame is abandoned by timeout.
REQ-013 SHALL have port busy  out  1  high while a frame is partially received.

Function
REQ-014 SHALL transfer a byte on any cycle where seg_valid and seg_ready are both high; seg_valid without seg_ready SHALL have no effect.
REQ-015 SHALL use states IDLE (seg_ready=1, busy=0), CAPTURE (seg_ready=1, busy=1) and COMMIT (seg_ready=0, busy=0, one cycle).
REQ-016 SHALL store the first byte of a frame as digit 7 and move IDLE->CAPTURE; each later byte goes to the next lower index down to digit 0.
REQ-017 SHALL go CAPTURE->COMMIT on acceptance of digit 0, and COMMIT->IDLE unconditionally.
REQ-018 SHALL decode gate segments g..a with the display table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex, bit7 excluded).
REQ-019 SHALL store digit 0 and set the matching shadow bad bit for any other 7-bit pattern, blank (00) included.
REQ-020 SHALL collect digits, dp bits and bad bits in a shadow buffer and copy the buffer to digits, flt_pt and bad_digit only in COMMIT, with frame_valid=1 in that cycle.
REQ-021 SHALL therefore show the first frame's outputs and frame_valid one cycle after digit 0 is accepted.
REQ-022 SHALL leave outputs unchanged between commits, and also after an abandoned frame.
REQ-023 SHALL, on frame_start in CAPTURE, clear the shadow and set the index to 7; if a byte transfers in the same cycle, that byte SHALL be stored as digit 7 of the new frame.
REQ-024 SHALL ignore frame_start in IDLE and COMMIT.
REQ-025 SHALL clear the idle counter on every accepted byte and count non-accepting cycles only in CAPTURE.
REQ-026 SHALL, when the count reaches TIMEOUT_CYCLES, pulse timeout for one cycle, discard the shadow and return to IDLE.
REQ-027 SHALL give a transfer in the same cycle priority over the timeout.
REQ-028 SHALL size the idle counter to $clog2(TIMEOUT_CYCLES+1) bits, saturating, with no wrap.

Reset
REQ-029 SHALL, while reset is high, force state IDLE, index 7, idle counter 0, shadow 0, and the outputs digits=0, flt_pt=0, bad_digit=0, frame_valid=0, timeout=0, busy=0.
REQ-030 SHALL drive seg_ready=0 during reset and 1 on the first cycle after reset deasserts.
REQ-031 SHALL discard a partial frame on reset mid-frame with no frame_valid or timeout pulse.

Configuration
REQ-032 SHALL, with SS_DECODE_DP_EN defined, capture seg_in[7] into the shadow dp bit of the current digit and commit it to flt_pt.
REQ-033 SHALL, without SS_DECODE_DP_EN, ignore seg_in[7], tie flt_pt to 0 and remove the dp shadow register.

Structure
REQ-034 SHALL take from package ss_pkg: SEG_0..SEG_F pattern constants, NUM_DIGITS=8, and the state enum ss_cap_state_t.
REQ-035 SHALL place the decode in one combinational sub-module seg_to_hex: 7-bit pattern in, {known, nibble} out, shared with future blocks.

Verification
REQ-036 SHALL cover: bytes 7C,77,5E,7C,77,5E,3F,3F on consecutive cycles -> one-cycle frame_valid the cycle after the 8th byte, digits=BADBAD00, bad_digit=00, seg_ready=0 in the COMMIT cycle.
REQ-037 SHALL cover: frame 3F,06,5B,4F,00,6D,7D,07 -> digits=01230567, bad_digit=08.
REQ-038 SHALL cover: dp set on the 8th byte only (BF) -> flt_pt=01 with SS_DECODE_DP_EN; flt_pt=00 and the same digits without it.
REQ-039 SHALL cover: 3 bytes then 100 idle cycles -> timeout pulses on the 100th idle cycle, busy falls, prior digits are kept, and the next byte is digit 7.
REQ-040 SHALL cover: 5 bytes, then frame_start together with byte 71, then 7 more bytes -> digits[7]=F, with a single frame_valid.
REQ-041 SHALL cover: reset asserted after 4 bytes -> all outputs 0, no pulses, and a clean frame accepted afterwards.
